// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// mem writeback paths, plus the busy scoreboard used for RAW hazard stalls.
module wb_port_arbiter #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [4:0]      req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    input  logic            set_en,
    input  logic [4:0]      set_addr,
    input  logic            flush,
    input  logic [4:0]      chk_addr1,
    input  logic [4:0]      chk_addr2,
    output logic            busy1,
    output logic            busy2,
    output logic            busy_any
);

    logic             prio_q, prio_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             grant0, grant1;

    always_comb begin
        // Grants are gated by reset so ready stays low while the block is held in reset.
        grant0 = reset && req0_valid && (!req1_valid || !prio_q);
        grant1 = reset && req1_valid && (!req0_valid ||  prio_q);

        prio_d = prio_q;
        if (req0_valid && req1_valid) begin
            prio_d = grant0;
        end

        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (grant0) begin
            wb_en_d = (req0_addr != '0);
            if (req0_addr != '0) begin
                wb_addr_d = req0_addr;
                wb_data_d = req0_data;
            end
        end else if (grant1) begin
            wb_en_d = (req1_addr != '0);
            if (req1_addr != '0) begin
                wb_addr_d = req1_addr;
                wb_data_d = req1_data;
            end
        end

        // Clear on commit first so a same-cycle set of the same register wins.
        busy_d = busy_q;
        if (wb_en_q) begin
            busy_d[wb_addr_q] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_d[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            prio_q    <= prio_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign wb_en      = wb_en_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign busy1      = (chk_addr1 != '0) && busy_q[chk_addr1];
    assign busy2      = (chk_addr2 != '0) && busy_q[chk_addr2];
    assign busy_any   = |busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: table of per-cycle stimulus with expected grants,
// writeback results checked one cycle later through an expectation queue.
module tb_wb_port_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req1_valid;
    logic [4:0]      req0_addr, req1_addr;
    logic [XLEN-1:0] req0_data, req1_data;
    logic            req0_ready, req1_ready;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            set_en, flush;
    logic [4:0]      set_addr, chk_addr1, chk_addr2;
    logic            busy1, busy2, busy_any;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .set_en(set_en), .set_addr(set_addr), .flush(flush),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .busy1(busy1), .busy2(busy2), .busy_any(busy_any)
    );

    typedef struct {
        logic            r0v;
        logic [4:0]      r0a;
        logic [XLEN-1:0] r0d;
        logic            r1v;
        logic [4:0]      r1a;
        logic [XLEN-1:0] r1d;
        logic            se;
        logic [4:0]      sa;
        logic            fl;
        logic [4:0]      c1;
        logic [4:0]      c2;
        logic            e0;
        logic            e1;
    } vec_t;

    typedef struct {
        logic            en;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_t;

    int errors = 0;
    int checks = 0;
    wb_t exp_q[$];

    logic            m_prio;
    logic [31:0]     m_busy;
    logic            m_wb_en;
    logic [4:0]      m_wb_addr;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r0v, input logic [4:0] r0a, input logic [XLEN-1:0] r0d,
                                input logic r1v, input logic [4:0] r1a, input logic [XLEN-1:0] r1d,
                                input logic se, input logic [4:0] sa, input logic fl,
                                input logic [4:0] c1, input logic [4:0] c2,
                                input logic e0, input logic e1);
        vec_t v;
        v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
        v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
        v.se = se; v.sa = sa; v.fl = fl; v.c1 = c1; v.c2 = c2;
        v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        req0_valid = v.r0v; req0_addr = v.r0a; req0_data = v.r0d;
        req1_valid = v.r1v; req1_addr = v.r1a; req1_data = v.r1d;
        set_en = v.se; set_addr = v.sa; flush = v.fl;
        chk_addr1 = v.c1; chk_addr2 = v.c2;
    endtask

    // Called at posedge+1: drive, check combinational outputs mid-cycle, then check the registered write.
    task automatic run_cycle(input vec_t v, input string tag);
        logic        g0, g1;
        logic [31:0] nb;
        wb_t         e;
        apply(v);
        @(negedge clk);
        g0 = v.r0v && (!v.r1v || !m_prio);
        g1 = v.r1v && (!v.r0v ||  m_prio);
        chk({tag, ".ready0"}, {63'd0, req0_ready}, {63'd0, v.e0});
        chk({tag, ".ready1"}, {63'd0, req1_ready}, {63'd0, v.e1});
        chk({tag, ".busy1"}, {63'd0, busy1}, {63'd0, (v.c1 != 5'd0) && m_busy[v.c1]});
        chk({tag, ".busy2"}, {63'd0, busy2}, {63'd0, (v.c2 != 5'd0) && m_busy[v.c2]});
        chk({tag, ".busy_any"}, {63'd0, busy_any}, {63'd0, |m_busy});
        e.en = 1'b0; e.addr = '0; e.data = '0;
        if (g0) begin
            e.en = (v.r0a != 5'd0); e.addr = v.r0a; e.data = v.r0d;
        end else if (g1) begin
            e.en = (v.r1a != 5'd0); e.addr = v.r1a; e.data = v.r1d;
        end
        exp_q.push_back(e);
        nb = m_busy;
        if (m_wb_en) nb[m_wb_addr] = 1'b0;
        if (v.se && v.sa != 5'd0) nb[v.sa] = 1'b1;
        if (v.fl) nb = '0;
        m_busy = nb;
        if (v.r0v && v.r1v) m_prio = g0;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".wb_en"}, {63'd0, wb_en}, {63'd0, e.en});
            if (e.en) begin
                chk({tag, ".wb_addr"}, {59'd0, wb_addr}, {59'd0, e.addr});
                chk({tag, ".wb_data"}, wb_data, e.data);
            end
            m_wb_en = e.en;
            if (e.en) m_wb_addr = e.addr;
        end
    endtask

    initial begin
        vec_t v;
        //           r0v r0a   r0d     r1v r1a   r1d     se  sa    fl  c1     c2     e0 e1
        tbl[0]  = mk(1, 5'd5, 64'hAA,  0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd0,  5'd0,  1, 0);
        tbl[1]  = mk(0, 5'd0, 64'h0,   1, 5'd0, 64'h55, 1, 5'd0,  0, 5'd0,  5'd0,  0, 1);
        tbl[2]  = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd0,  5'd0,  0, 0);
        tbl[3]  = mk(1, 5'd3, 64'h31,  1, 5'd4, 64'h41, 0, 5'd0,  0, 5'd3,  5'd4,  1, 0);
        tbl[4]  = mk(1, 5'd3, 64'h32,  1, 5'd4, 64'h41, 0, 5'd0,  0, 5'd3,  5'd4,  0, 1);
        tbl[5]  = mk(1, 5'd3, 64'h32,  1, 5'd4, 64'h42, 0, 5'd0,  0, 5'd3,  5'd4,  1, 0);
        tbl[6]  = mk(1, 5'd3, 64'h33,  1, 5'd4, 64'h42, 0, 5'd0,  0, 5'd3,  5'd4,  0, 1);
        tbl[7]  = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  1, 5'd7,  0, 5'd7,  5'd0,  0, 0);
        tbl[8]  = mk(1, 5'd7, 64'h77,  0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd7,  5'd0,  1, 0);
        tbl[9]  = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd7,  5'd0,  0, 0);
        tbl[10] = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd7,  5'd0,  0, 0);
        tbl[11] = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  1, 5'd9,  0, 5'd0,  5'd9,  0, 0);
        tbl[12] = mk(1, 5'd9, 64'h99,  0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd0,  5'd9,  1, 0);
        tbl[13] = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  1, 5'd9,  0, 5'd0,  5'd9,  0, 0);
        tbl[14] = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd0,  5'd9,  0, 0);
        tbl[15] = mk(0, 5'd0, 64'h0,   1, 5'd9, 64'h9A, 0, 5'd0,  0, 5'd0,  5'd9,  0, 1);
        tbl[16] = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  1, 5'd10, 1, 5'd10, 5'd9,  0, 0);
        tbl[17] = mk(0, 5'd0, 64'h0,   0, 5'd0, 64'h0,  0, 5'd0,  0, 5'd10, 5'd9,  0, 0);

        m_prio = 1'b0; m_busy = '0; m_wb_en = 1'b0; m_wb_addr = '0;

        // Held in reset with both requesters asserting.
        reset = 1'b0;
        apply(mk(1, 5'd3, 64'h1, 1, 5'd4, 64'h2, 1, 5'd6, 0, 5'd6, 5'd0, 0, 0));
        #12;
        chk("rst.wb_en",    {63'd0, wb_en},      64'd0);
        chk("rst.wb_addr",  {59'd0, wb_addr},    64'd0);
        chk("rst.wb_data",  wb_data,             64'd0);
        chk("rst.busy_any", {63'd0, busy_any},   64'd0);
        chk("rst.ready0",   {63'd0, req0_ready}, 64'd0);
        chk("rst.ready1",   {63'd0, req1_ready}, 64'd0);
        @(negedge clk);
        apply(mk(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            run_cycle(tbl[i], $sformatf("vec%0d", i));
        end

        // Async reset between edges with a write pending and a busy bit set.
        run_cycle(mk(1, 5'd6, 64'h66, 1, 5'd8, 64'h88, 1, 5'd12, 0, 5'd12, 5'd6, 1, 0), "pre_arst");
        apply(mk(1, 5'd6, 64'h67, 1, 5'd8, 64'h88, 0, 5'd0, 0, 5'd12, 5'd6, 0, 0));
        #1;
        chk("pre_arst.wb_en",    {63'd0, wb_en},    64'd1);
        chk("pre_arst.busy_any", {63'd0, busy_any}, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst.wb_en",    {63'd0, wb_en},      64'd0);
        chk("arst.wb_addr",  {59'd0, wb_addr},    64'd0);
        chk("arst.wb_data",  wb_data,             64'd0);
        chk("arst.busy_any", {63'd0, busy_any},   64'd0);
        chk("arst.busy1",    {63'd0, busy1},      64'd0);
        chk("arst.ready0",   {63'd0, req0_ready}, 64'd0);
        chk("arst.ready1",   {63'd0, req1_ready}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
